// File: rtl/dmem_lsu.sv
// Load/store unit between the core data port and a word-organised SRAM.
// Optional build macro: MISALIGN_TRAP_EN (trap misaligned half/word instead of truncating the address).
module dmem_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      resp_err,
    output logic                      mem_sel,
    output logic                      mem_we,
    output logic [3:0]                mem_byte_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_din,
    input  logic [DATA_WIDTH-1:0]     mem_dout,
    input  logic                      mem_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state_q;
    logic                      req_ready_q;
    logic                      we_q;
    logic [1:0]                size_q;
    logic                      uns_q;
    logic [1:0]                off_q;
    logic                      resp_valid_q;
    logic                      resp_err_q;
    logic [DATA_WIDTH-1:0]     resp_rdata_q;
    logic                      mem_sel_q;
    logic                      mem_we_q;
    logic [3:0]                mem_byte_en_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]     mem_din_q;

    logic [1:0]            off_d;
    logic                  legal_d;
    logic [3:0]            byte_en_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  unused_addr;

    assign unused_addr = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    always_comb begin
        off_d   = req_addr[1:0];
        legal_d = (req_size != 2'd3);
`ifdef MISALIGN_TRAP_EN
        if (req_size == 2'd1 && req_addr[0])
            legal_d = 1'b0;
        if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
            legal_d = 1'b0;
`else
        // Misaligned half/word accesses silently drop the offending low bits.
        if (req_size == 2'd1)
            off_d = {req_addr[1], 1'b0};
        else if (req_size == 2'd2)
            off_d = 2'b00;
`endif
    end

    always_comb begin
        case (req_size)
            2'd0:    byte_en_d = 4'b0001 << off_d;
            2'd1:    byte_en_d = 4'b0011 << off_d;
            default: byte_en_d = 4'b1111;
        endcase
    end

    // Store data is replicated so every lane the byte enables may select carries it.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign din_d[gi*8 +: 8] = (req_size == 2'd0) ? req_wdata[7:0] :
                                  (req_size == 2'd1) ? req_wdata[(gi%2)*8 +: 8] :
                                                       req_wdata[gi*8 +: 8];
    end

    assign lane = mem_dout >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    load_ext = {{24{~uns_q & lane[7]}},  lane[7:0]};
            2'd1:    load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            we_q          <= 1'b0;
            size_q        <= 2'd0;
            uns_q         <= 1'b0;
            off_q         <= 2'd0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_sel_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_byte_en_q <= 4'b0000;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        off_q       <= off_d;
                        req_ready_q <= 1'b0;
                        if (legal_d) begin
                            state_q       <= ISSUE;
                            mem_sel_q     <= 1'b1;
                            mem_we_q      <= req_we;
                            mem_byte_en_q <= byte_en_d;
                            mem_addr_q    <= req_addr[MEM_ADDR_WIDTH+1:2];
                            mem_din_q     <= din_d;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_sel_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (mem_ack) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? '0 : load_ext;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_sel     = mem_sel_q;
    assign mem_we      = mem_we_q;
    assign mem_byte_en = mem_byte_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a behavioural SRAM that acks one
// cycle after select, plus an optional stall count and a stray-ack injector.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_sel;
    logic        mem_we;
    logic [3:0]  mem_byte_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;

    dmem_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_sel(mem_sel), .mem_we(mem_we),
        .mem_byte_en(mem_byte_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM
    logic [31:0] mem [0:1023];
    logic        pend = 1'b0;
    int          wait_cnt = 0;
    int          stall = 0;
    logic [31:0] rd_lat = '0;
    logic        stray = 1'b0;

    always @(posedge clk) begin
        if (mem_sel) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_byte_en[b]) mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            rd_lat   <= mem[mem_addr];
            pend     <= 1'b1;
            wait_cnt <= stall;
        end else if (pend) begin
            if (wait_cnt == 0) pend <= 1'b0;
            else               wait_cnt <= wait_cnt - 1;
        end
    end
    assign mem_ack  = (pend && wait_cnt == 0) || stray;
    assign mem_dout = (pend && wait_cnt == 0) ? rd_lat : 32'h0;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Result fields of the most recent transaction
    logic [31:0] r_rd;
    logic        r_err;
    int          r_lat, r_sel, r_we;
    logic [3:0]  r_be;
    logic [9:0]  r_ma;
    logic [31:0] r_din;
    logic        r_stable, r_rdy, r_after;

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_lat = 0; r_sel = 0; r_we = 0; r_be = '0; r_ma = '0; r_din = '0;
        r_stable = 1'b1; r_rdy = 1'b0;
        while (!resp_valid && r_lat < 50) begin
            if (mem_sel) begin
                r_sel++; r_be = mem_byte_en; r_ma = mem_addr; r_din = mem_din;
            end else if (r_sel > 0 && mem_addr !== r_ma) begin
                r_stable = 1'b0;
            end
            if (mem_we) r_we++;
            r_rdy = r_rdy | req_ready;
            @(posedge clk); #1;
            r_lat++;
        end
        r_rd = resp_rdata; r_err = resp_err;
        @(posedge clk); #1;
        r_after = resp_valid;
    endtask

    initial begin
        logic seen;
        // Reset state
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_sel_we", {30'd0, mem_sel, mem_we}, 32'd0);
        check("rst_be_addr", {18'd0, mem_byte_en, mem_addr}, 32'd0);
        check("rst_din", mem_din, 32'd0);
        check("rst_rdata_err", resp_rdata | {31'd0, resp_err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: sw 0xDEADBEEF @0x10
        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_sel_cycles", r_sel, 1);
        check("sw_we_cycles", r_we, 1);
        check("sw_be", {28'd0, r_be}, 32'hF);
        check("sw_addr", {22'd0, r_ma}, 32'd4);
        check("sw_din", r_din, 32'hDEADBEEF);
        check("sw_latency", r_lat, 2);
        check("sw_err", {31'd0, r_err}, 32'd0);
        check("sw_rdata", r_rd, 32'd0);
        check("sw_resp_one_cycle", {31'd0, r_after}, 32'd0);

        // 2: sub-word loads
        xact(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check("lb_13", r_rd, 32'hFFFFFFDE);
        check("load_we_cycles", r_we, 0);
        xact(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lbu_13", r_rd, 32'h000000DE);
        xact(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        check("lhu_10", r_rd, 32'h0000BEEF);
        xact(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        check("lh_12", r_rd, 32'hFFFFDEAD);

        // 3: sb 0x55 @0x11 then lw
        xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055);
        check("sb_be", {28'd0, r_be}, 32'b0010);
        check("sb_din", r_din, 32'h55555555);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_after_sb", r_rd, 32'hDEAD55EF);

        // 4: SRAM stalls 5 cycles in WAIT
        stall = 5;
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        stall = 0;
        check("stall_latency", r_lat, 7);
        check("stall_addr_stable", {31'd0, r_stable}, 32'd1);
        check("stall_ready_low", {31'd0, r_rdy}, 32'd0);
        check("stall_rdata", r_rd, 32'hDEAD55EF);

        // Half store into the upper lanes
        xact(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
        check("sh_be", {28'd0, r_be}, 32'b1100);
        check("sh_din", r_din, 32'h12341234);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_after_sh", r_rd, 32'h123455EF);

        // 5: misaligned and reserved-size requests
        xact(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("mis_lw_err", {31'd0, r_err}, 32'd1);
        check("mis_lw_latency", r_lat, 0);
        check("mis_lw_nosel", r_sel, 0);
        check("mis_lw_rdata", r_rd, 32'd0);
`else
        check("mis_lw_err", {31'd0, r_err}, 32'd0);
        check("mis_lw_addr", {22'd0, r_ma}, 32'd4);
        check("mis_lw_rdata", r_rd, 32'h123455EF);
`endif
        xact(1'b0, 2'd1, 1'b1, 32'h13, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("mis_lhu_err", {31'd0, r_err}, 32'd1);
`else
        check("mis_lhu_rdata", r_rd, 32'h00001234);
`endif
        xact(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF);
        check("size3_err", {31'd0, r_err}, 32'd1);
        check("size3_rdata", r_rd, 32'd0);
        check("size3_nosel", r_sel + r_we, 0);
        check("size3_latency", r_lat, 0);

        // Stray ack while idle is ignored
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        check("stray_no_resp", {31'd0, resp_valid}, 32'd0);
        check("stray_ready", {31'd0, req_ready}, 32'd1);

        // 6: reset during WAIT
        stall = 5;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b0; #1;
        check("abort_sel_we", {30'd0, mem_sel, mem_we}, 32'd0);
        check("abort_addr", {22'd0, mem_addr}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen = seen | resp_valid;
        end
        stall = 0;
        check("abort_no_resp", {31'd0, seen}, 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("post_abort_lw", r_rd, 32'h123455EF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
